// File: rtl/reg_file.sv
// Three-port register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module reg_file #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWr,
    input  logic [DEPTH_LOG2-1:0] Rw,
    input  logic [WIDTH-1:0]      busW,
    input  logic [DEPTH_LOG2-1:0] Ra,
    input  logic [DEPTH_LOG2-1:0] Rb,
    output logic [WIDTH-1:0]      busA,
    output logic [WIDTH-1:0]      busB
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             w_wr_ok;
    logic             w_byp_a;
    logic             w_byp_b;

    assign w_wr_ok = RegWr && !rst && (Rw != '0);

    // Entry 0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '{default: '0};
        end else if (w_wr_ok) begin
            r_regs[Rw] <= busW;
        end
    end

    assign w_byp_a = (BYPASS != 0) && w_wr_ok && (Ra == Rw);
    assign w_byp_b = (BYPASS != 0) && w_wr_ok && (Rb == Rw);

    always_comb begin
        busA = r_regs[Ra];
        if (Ra == '0) begin
            busA = '0;
        end else if (w_byp_a) begin
            busA = busW;
        end
    end

    always_comb begin
        busB = r_regs[Rb];
        if (Rb == '0) begin
            busB = '0;
        end else if (w_byp_b) begin
            busB = busW;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one bypassed and one non-bypassed instance share the same stimulus.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA1, busB1, busA0, busB0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW),
        .Ra(Ra), .Rb(Rb), .busA(busA1), .busB(busB1)
    );

    reg_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW),
        .Ra(Ra), .Rb(Rb), .busA(busA0), .busB(busB0)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea1;
        logic [31:0] eb1;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] mem [32];
    logic [31:0] nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s Ra=%0d Rb=%0d actual=%h required=%h", name, Ra, Rb, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] a0, input logic [31:0] b0);
        chk({name, "_A_byp"}, busA1, a1);
        chk({name, "_B_byp"}, busB1, b1);
        chk({name, "_A_nob"}, busA0, a0);
        chk({name, "_B_nob"}, busB0, b0);
    endtask

    initial begin
        // Pre-edge expectations; the write (if any) lands on the following rising edge.
        tbl[0]  = '{1'b1, 5'd1,  32'h00000003, 5'd1, 5'd2,  32'h00000003, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b1, 5'd2,  32'h00000001, 5'd1, 5'd2,  32'h00000003, 32'h00000001, 32'h00000003, 32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd2,  32'h00000003, 32'h00000001, 32'h00000003, 32'h00000001};
        tbl[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        tbl[4]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd1,  32'h0,        32'h00000003, 32'h0,        32'h00000003};
        tbl[5]  = '{1'b1, 5'd7,  32'h11111111, 5'd7, 5'd1,  32'h11111111, 32'h00000003, 32'h0,        32'h00000003};
        tbl[6]  = '{1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7,  32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111};
        tbl[7]  = '{1'b0, 5'd7,  32'h33333333, 5'd7, 5'd2,  32'h22222222, 32'h00000001, 32'h22222222, 32'h00000001};
        tbl[8]  = '{1'b1, 5'd3,  32'hAAAA5555, 5'd3, 5'd3,  32'hAAAA5555, 32'hAAAA5555, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 5'd3,  32'h0,        5'd3, 5'd7,  32'hAAAA5555, 32'h22222222, 32'hAAAA5555, 32'h22222222};
        tbl[10] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd7, 5'd31, 32'h22222222, 32'hCAFEF00D, 32'h22222222, 32'h0};
        tbl[11] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};

        rst = 1'b1; RegWr = 1'b1; Rw = 5'd5; busW = 32'h5A5A5A5A; Ra = 5'd5; Rb = 5'd31;
        @(negedge clk); #1;
        chk_all("reset_state", '0, '0, '0, '0);

        // Preload r5, then pulse reset between edges.
        rst = 1'b0; RegWr = 1'b1; Rw = 5'd5; busW = 32'hDEADBEEF; Ra = 5'd0; Rb = 5'd0;
        @(negedge clk);
        RegWr = 1'b0; Ra = 5'd5; Rb = 5'd5;
        #1 chk_all("preload", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk_all("rst_async", '0, '0, '0, '0);
        rst = 1'b0;
        #1 chk_all("rst_released", '0, '0, '0, '0);

        // Reset held across an edge with a pending write: write is lost, no forwarding.
        @(negedge clk);
        rst = 1'b1; RegWr = 1'b1; Rw = 5'd4; busW = 32'h12345678; Ra = 5'd4; Rb = 5'd4;
        #2 chk_all("rst_wr_pre", '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0; RegWr = 1'b0;
        #1 chk_all("rst_wr_lost", '0, '0, '0, '0);

        foreach (tbl[k]) begin
            @(negedge clk);
            RegWr = tbl[k].wr; Rw = tbl[k].rw; busW = tbl[k].busw; Ra = tbl[k].ra; Rb = tbl[k].rb;
            #2 chk_all($sformatf("vec%0d", k), tbl[k].ea1, tbl[k].eb1, tbl[k].ea0, tbl[k].eb0);
        end

        foreach (mem[k]) mem[k] = '0;
        mem[1] = 32'h00000003; mem[2] = 32'h00000001; mem[3] = 32'hAAAA5555;
        mem[7] = 32'h22222222; mem[31] = 32'hCAFEF00D;

        // Sweep writes r_i = i*01010101, checking forwarding vs old contents on the fly.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            nv = 32'h01010101 * 32'(i);
            RegWr = 1'b1; Rw = 5'(i); busW = nv; Ra = 5'(i); Rb = 5'd0;
            #2 chk_all("sweep_wr", nv, '0, mem[i], '0);
            mem[i] = nv;
        end

        @(negedge clk);
        RegWr = 1'b0; Rw = 5'd9; busW = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                Ra = 5'(a); Rb = 5'(b);
                #1 chk_all("sweep_rd", mem[a], mem[b], mem[a], mem[b]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
